// File: rtl/memory_cycle_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : memory_cycle_lsu_pkg
// Purpose  : funct3 codes, FSM state type and byte-enable helper for the LSU
// Revision : 1.0 - initial release
// ============================================================================
package memory_cycle_lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } lsu_state_t;

    // size is funct3[1:0]: 00 byte, 01 half, otherwise word
    function automatic logic [3:0] byteEnable(input logic [1:0] size, input logic [1:0] addrLo);
        case (size)
            2'b00:   return 4'b0001 << addrLo;
            2'b01:   return addrLo[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/memory_cycle_lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : memory_cycle_lsu_if
// Purpose  : req/ack data-memory port with byte enables
// Revision : 1.0 - initial release
// ============================================================================
interface memory_cycle_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
        output dmem_ack, dmem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/memory_cycle_lsu_load_extend.sv
`default_nettype none
// ============================================================================
// Module   : load_extend
// Purpose  : selects the addressed byte/half of a read word and extends it
// Revision : 1.0 - initial release
// ============================================================================
module load_extend
    import memory_cycle_lsu_pkg::*;
(
    input  wire logic [31:0] i_rdata,
    input  wire logic [1:0]  i_addrLo,
    input  wire logic [2:0]  i_funct3,
    output logic      [31:0] o_extData
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        case (i_addrLo)
            2'b00:   w_byte = i_rdata[7:0];
            2'b01:   w_byte = i_rdata[15:8];
            2'b10:   w_byte = i_rdata[23:16];
            default: w_byte = i_rdata[31:24];
        endcase
        w_half = i_addrLo[1] ? i_rdata[31:16] : i_rdata[15:0];

        case (i_funct3)
            F3_B:    o_extData = {{24{w_byte[7]}}, w_byte};
            F3_BU:   o_extData = {24'd0, w_byte};
            F3_H:    o_extData = {{16{w_half[15]}}, w_half};
            F3_HU:   o_extData = {16'd0, w_half};
            default: o_extData = i_rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/memory_cycle_lsu.sv
`default_nettype none
// ============================================================================
// Module   : memory_cycle_lsu
// Purpose  : RV32I MEM stage - req/ack data port, load extend, stall, MEM/WB
// Revision : 1.0 - initial release
// ============================================================================
module memory_cycle_lsu
    import memory_cycle_lsu_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    input  wire logic          RegWriteM,
    input  wire logic [1:0]    ResultSrcM,
    input  wire logic          LoadM,
    input  wire logic          StoreM,
    input  wire logic [4:0]    RD_M,
    input  wire logic [31:0]   PCPlus4M,
    input  wire logic [31:0]   WriteDataM,
    input  wire logic [31:0]   ALU_ResultM,
    input  wire logic [31:0]   InstrM,
    memory_cycle_lsu_if.master dmem,
    output logic               StallM,
    output logic               RegWriteW,
    output logic [1:0]         ResultSrcW,
    output logic [4:0]         RD_W,
    output logic [31:0]        PCPlus4W,
    output logic [31:0]        ALU_ResultW,
    output logic [31:0]        ReadDataW,
    output logic [31:0]        InstrW,
    output logic               MisalignW,
    output logic               BusErrW
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]  w_f3;
    logic        w_memOp;
    logic        w_f3Ok;
    logic        w_misalign;
    logic        w_access;
    logic        w_expired;
    logic        w_done;
    logic        w_timeout;
    logic [31:0] w_ext;

    assign w_f3    = InstrM[14:12];
    assign w_memOp = LoadM | StoreM;

    always_comb begin
        w_f3Ok = 1'b0;
        case (w_f3)
            F3_B, F3_H, F3_W: w_f3Ok = 1'b1;
            F3_BU, F3_HU:     w_f3Ok = ~StoreM;
            default:          w_f3Ok = 1'b0;
        endcase
    end

    assign w_misalign = w_memOp & (~w_f3Ok
                      | ((w_f3[1:0] == 2'b01) & ALU_ResultM[0])
                      | ((w_f3[1:0] == 2'b10) & (ALU_ResultM[1:0] != 2'b00)));
    assign w_access   = w_memOp & ~w_misalign;

    // The last WAIT cycle still carries the request so a coinciding ack completes normally
    assign w_expired  = (r_state == S_WAIT) && (r_cnt == CNT_W'(TIMEOUT - 1));
    assign w_done     = w_access & dmem.dmem_ack;
    assign w_timeout  = w_expired & ~dmem.dmem_ack;

    // Gated with rst so an asynchronous reset drops req/stall without waiting for a clock
    assign dmem.dmem_req = rst & w_access;
    assign StallM        = rst & w_access & ~dmem.dmem_ack & ~w_expired;

    assign dmem.dmem_we   = StoreM;
    assign dmem.dmem_addr = {ALU_ResultM[31:2], 2'b00};
    assign dmem.dmem_be   = byteEnable(w_f3[1:0], ALU_ResultM[1:0]);

    always_comb begin
        case (w_f3[1:0])
            2'b00:   dmem.dmem_wdata = {4{WriteDataM[7:0]}};
            2'b01:   dmem.dmem_wdata = {2{WriteDataM[15:0]}};
            default: dmem.dmem_wdata = WriteDataM;
        endcase
    end

    load_extend u_loadExtend (
        .i_rdata   (dmem.dmem_rdata),
        .i_addrLo  (ALU_ResultM[1:0]),
        .i_funct3  (w_f3),
        .o_extData (w_ext)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            RegWriteW   <= 1'b0;
            ResultSrcW  <= 2'b00;
            RD_W        <= 5'd0;
            PCPlus4W    <= 32'd0;
            ALU_ResultW <= 32'd0;
            ReadDataW   <= 32'd0;
            InstrW      <= 32'd0;
            MisalignW   <= 1'b0;
            BusErrW     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_access && !dmem.dmem_ack) begin
                        r_state <= S_WAIT;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (dmem.dmem_ack || w_expired) r_state <= S_IDLE;
                    else                            r_cnt   <= r_cnt + CNT_W'(1);
                end
                default: r_state <= S_IDLE;
            endcase

            ResultSrcW  <= ResultSrcM;
            RD_W        <= RD_M;
            PCPlus4W    <= PCPlus4M;
            ALU_ResultW <= ALU_ResultM;
            InstrW      <= InstrM;

            if (StallM) begin
                RegWriteW <= 1'b0;
                MisalignW <= 1'b0;
                BusErrW   <= 1'b0;
            end else begin
                RegWriteW <= RegWriteM & ~w_misalign & ~w_timeout;
                MisalignW <= w_misalign;
                BusErrW   <= w_timeout;
            end

            if (w_done) ReadDataW <= StoreM ? 32'd0 : w_ext;
        end
    end

endmodule
`default_nettype wire
